// File: rtl/i2c_wb_arbiter_if.sv
// Bus bundle between the channel drivers / EFB and the Wishbone arbiter.
// The arbiter takes the slave view; whatever drives the channels and models the EFB takes the master view.
interface i2c_wb_arbiter_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]   ch_cyc_i;
  logic [NUM_CH-1:0]   ch_stb_i;
  logic [NUM_CH-1:0]   ch_we_i;
  logic [8*NUM_CH-1:0] ch_adr_i;
  logic [8*NUM_CH-1:0] ch_dat_i;
  logic [7:0]          ch_dat_o;
  logic [NUM_CH-1:0]   ch_ack_o;
  logic [NUM_CH-1:0]   ch_gnt_o;
  logic [NUM_CH-1:0]   ch_err_o;
  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic                wb_we_o;
  logic [7:0]          wb_adr_o;
  logic [7:0]          wb_dat_o;
  logic [7:0]          wb_dat_i;
  logic                wb_ack_i;
  logic                busy_o;

  modport slave (
    input  ch_cyc_i, ch_stb_i, ch_we_i, ch_adr_i, ch_dat_i, wb_dat_i, wb_ack_i,
    output ch_dat_o, ch_ack_o, ch_gnt_o, ch_err_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, busy_o
  );

  modport master (
    output ch_cyc_i, ch_stb_i, ch_we_i, ch_adr_i, ch_dat_i, wb_dat_i, wb_ack_i,
    input  ch_dat_o, ch_ack_o, ch_gnt_o, ch_err_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, busy_o
  );
endinterface

// File: rtl/i2c_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the EFB I2C slave port among NUM_CH channel masters,
// with per-cycle bus lock and a per-strobe ack timeout that aborts a hung transfer.
module i2c_wb_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int TIMEOUT = 255
) (
  input logic             sys_clk,
  input logic             rstn,
  i2c_wb_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     winner, scan_idx;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              owner_cyc, efb_stb, timeout_fire;

  // Scan downward so the lowest offset from last_grant is the final assignment and wins.
  always_comb begin
    winner   = last_q;
    scan_idx = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      scan_idx = IW'((int'(last_q) + i) % NUM_CH);
      if (bus.ch_cyc_i[scan_idx]) winner = scan_idx;
    end
  end

  assign owner_cyc    = bus.ch_cyc_i[owner_q];
  assign efb_stb      = (state_q == OWN) && bus.ch_stb_i[owner_q];
  // An ack in the terminal cycle suppresses the timeout.
  assign timeout_fire = efb_stb && !bus.wb_ack_i && (cnt_q == 16'(TIMEOUT - 1));
  assign cnt_d        = (!efb_stb || bus.wb_ack_i) ? 16'd0 : cnt_q + 16'd1;

  // NOTE: every combinational output gets a default before any branch so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.ch_cyc_i) begin
          state_d        = OWN;
          owner_d        = winner;
          last_d         = winner;
          gnt_d          = '0;
          gnt_d[winner]  = 1'b1;
        end
      end
      OWN: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (timeout_fire) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.wb_cyc_o = 1'b0;
    bus.wb_stb_o = 1'b0;
    bus.wb_we_o  = 1'b0;
    bus.wb_adr_o = '0;
    bus.wb_dat_o = '0;
    bus.ch_ack_o = '0;
    bus.ch_err_o = '0;
    if (state_q == OWN) begin
      bus.wb_cyc_o          = owner_cyc;
      bus.wb_stb_o          = bus.ch_stb_i[owner_q];
      bus.wb_we_o           = bus.ch_we_i[owner_q];
      bus.wb_adr_o          = bus.ch_adr_i[{owner_q, 3'b000} +: 8];
      bus.wb_dat_o          = bus.ch_dat_i[{owner_q, 3'b000} +: 8];
      bus.ch_ack_o[owner_q] = bus.wb_ack_i;
    end
    if (timeout_fire) bus.ch_err_o[owner_q] = 1'b1;
  end

  assign bus.ch_dat_o = bus.wb_dat_i;
  assign bus.ch_gnt_o = gnt_q;
  assign bus.busy_o   = (state_q != IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_CH - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// Directed bench for i2c_wb_arbiter: 4 channels, TIMEOUT=8; grants and read data are
// predicted into scoreboard queues when stimulus is driven and popped when the DUT responds.
module tb_i2c_wb_arbiter;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rstn;
  int   vectors     = 0;
  int   miscompares = 0;

  int         exp_gnt_q[$];
  logic [7:0] exp_dat_q[$];

  i2c_wb_arbiter_if #(.NUM_CH(NCH)) bus ();

  i2c_wb_arbiter #(.NUM_CH(NCH), .TIMEOUT(8)) dut (
    .sys_clk (clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic raise(input int ch, input logic we, input logic [7:0] adr, input logic [7:0] dat);
    bus.ch_cyc_i[ch]          = 1'b1;
    bus.ch_stb_i[ch]          = 1'b1;
    bus.ch_we_i[ch]           = we;
    bus.ch_adr_i[ch*8 +: 8]   = adr;
    bus.ch_dat_i[ch*8 +: 8]   = dat;
  endtask

  task automatic drop(input int ch);
    bus.ch_cyc_i[ch] = 1'b0;
    bus.ch_stb_i[ch] = 1'b0;
  endtask

  // Waits for a non-zero grant, counting dead cycles; compares against the predicted owner.
  task automatic wait_grant(input string tag, input bit chk_idle);
    int         idle;
    int         exp_ch;
    bit         got;
    logic [3:0] exp_oh;
    idle = 0;
    got  = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      sample();
      if (bus.ch_gnt_o != '0) got = 1'b1;
      else idle++;
    end
    exp_ch = (exp_gnt_q.size() > 0) ? exp_gnt_q.pop_front() : 0;
    exp_oh = 4'b0001 << exp_ch;
    check({tag, " grant seen"}, 32'(got), 32'd1);
    check({tag, " grant"}, 32'(bus.ch_gnt_o), 32'(exp_oh));
    check({tag, " busy"}, 32'(bus.busy_o), 32'd1);
    if (chk_idle) check({tag, " dead cycles"}, 32'(idle), 32'd1);
  endtask

  // Owner is granted (first owned cycle sampled); wait, ack once, then drop cyc.
  task automatic serve(input string tag, input int ch, input int ack_wait,
                       input logic [7:0] rdata, input bit is_read);
    logic [3:0] own_oh;
    own_oh = 4'b0001 << ch;
    for (int i = 0; i < ack_wait; i++) begin
      step();
      sample();
      check({tag, " ack before EFB ack"}, 32'(bus.ch_ack_o), 32'd0);
    end
    step();
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = rdata;
    sample();
    check({tag, " ack routing"}, 32'(bus.ch_ack_o), 32'(own_oh));
    if (is_read) check({tag, " read data"}, 32'(bus.ch_dat_o), 32'(exp_dat_q.pop_front()));
    step();
    bus.wb_ack_i = 1'b0;
    drop(ch);
    sample();
    check({tag, " cyc released"}, 32'(bus.wb_cyc_o), 32'd0);
  endtask

  initial begin
    rstn         = 1'b0;
    bus.ch_cyc_i = '0;
    bus.ch_stb_i = '0;
    bus.ch_we_i  = '0;
    bus.ch_adr_i = '0;
    bus.ch_dat_i = '0;
    bus.wb_dat_i = 8'hA5;
    bus.wb_ack_i = 1'b0;
    step();
    step();
    sample();
    check("reset gnt", 32'(bus.ch_gnt_o), 32'd0);
    check("reset busy", 32'(bus.busy_o), 32'd0);
    check("reset wb_cyc", 32'(bus.wb_cyc_o), 32'd0);
    check("reset ack", 32'(bus.ch_ack_o), 32'd0);
    check("reset err", 32'(bus.ch_err_o), 32'd0);
    check("reset dat passthru", 32'(bus.ch_dat_o), 32'hA5);

    // Round-robin: all four request; ch0 re-requests once ch1 owns the bus.
    step();
    rstn = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      raise(c, 1'b0, 8'h10 + 8'(c), 8'h00);
      exp_gnt_q.push_back(c);
    end
    for (int n = 0; n < 5; n++) begin
      int ch;
      ch = n % NCH;
      wait_grant("rr", 1'b1);
      check("rr adr", 32'(bus.wb_adr_o), 32'h10 + 32'(ch));
      if (n == 1) begin
        raise(0, 1'b0, 8'h10, 8'h00);
        exp_gnt_q.push_back(0);
      end
      exp_dat_q.push_back(8'hA0 + 8'(ch));
      serve("rr", ch, 0, 8'hA0 + 8'(ch), 1'b1);
    end

    // Single requester: ch1 write, EFB acks on the third owned cycle.
    step();
    raise(1, 1'b1, 8'h4A, 8'h5C);
    exp_gnt_q.push_back(1);
    wait_grant("single", 1'b1);
    check("single wb_adr", 32'(bus.wb_adr_o), 32'h4A);
    check("single wb_dat", 32'(bus.wb_dat_o), 32'h5C);
    check("single wb_we", 32'(bus.wb_we_o), 32'd1);
    check("single wb_stb", 32'(bus.wb_stb_o), 32'd1);
    serve("single", 1, 2, 8'h00, 1'b0);

    // Lock: ch0 does three reads while ch1 requests continuously.
    step();
    raise(0, 1'b0, 8'h20, 8'h00);
    exp_gnt_q.push_back(0);
    wait_grant("lock", 1'b1);
    step();
    raise(1, 1'b1, 8'h21, 8'h77);
    exp_dat_q.push_back(8'h11);
    exp_dat_q.push_back(8'h22);
    exp_dat_q.push_back(8'h33);
    for (int r = 0; r < 3; r++) begin
      step();
      bus.wb_ack_i = 1'b1;
      bus.wb_dat_i = 8'(8'h11 * (r + 1));
      sample();
      check("lock ack", 32'(bus.ch_ack_o), 32'b0001);
      check("lock read data", 32'(bus.ch_dat_o), 32'(exp_dat_q.pop_front()));
      step();
      bus.wb_ack_i       = 1'b0;
      bus.ch_stb_i[0]    = 1'b0;
      sample();
      check("lock gap stb", 32'(bus.wb_stb_o), 32'd0);
      check("lock gap gnt", 32'(bus.ch_gnt_o), 32'b0001);
      step();
      bus.ch_stb_i[0] = 1'b1;
    end
    drop(0);
    exp_gnt_q.push_back(1);
    sample();
    check("lock cyc released", 32'(bus.wb_cyc_o), 32'd0);
    wait_grant("lock ch1", 1'b1);
    serve("lock ch1", 1, 0, 8'h00, 1'b0);

    // Timeout: ch2 strobes and the EFB never acks.
    step();
    raise(2, 1'b0, 8'h30, 8'h00);
    exp_gnt_q.push_back(2);
    wait_grant("timeout", 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) sample();
      check("timeout err", 32'(bus.ch_err_o), (k == 7) ? 32'b0100 : 32'd0);
    end
    sample();
    check("abort stb", 32'(bus.wb_stb_o), 32'd0);
    check("abort err", 32'(bus.ch_err_o), 32'd0);
    repeat (3) sample();
    check("abort busy", 32'(bus.busy_o), 32'd1);
    check("abort gnt", 32'(bus.ch_gnt_o), 32'b0100);
    step();
    drop(2);
    sample();
    check("abort busy at drop", 32'(bus.busy_o), 32'd1);
    sample();
    check("abort released", 32'(bus.busy_o), 32'd0);

    // Ack/timeout collision: ch3 acked in the cycle the counter reaches 7.
    step();
    raise(3, 1'b1, 8'h40, 8'h99);
    exp_gnt_q.push_back(3);
    wait_grant("collide", 1'b1);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 7) bus.wb_ack_i = 1'b1;
      sample();
      check("collide err", 32'(bus.ch_err_o), 32'd0);
    end
    check("collide ack", 32'(bus.ch_ack_o), 32'b1000);
    step();
    bus.wb_ack_i = 1'b0;
    sample();
    check("collide still own", 32'(bus.wb_stb_o), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      sample();
      check("collide counter cleared", 32'(bus.ch_err_o), 32'd0);
    end
    step();
    drop(3);
    sample();
    sample();
    check("collide released", 32'(bus.busy_o), 32'd0);

    // Reset while ch1 owns the bus with stb high.
    step();
    raise(1, 1'b1, 8'h55, 8'h66);
    exp_gnt_q.push_back(1);
    wait_grant("rst", 1'b1);
    step();
    rstn = 1'b0;
    sample();
    check("rst pre-edge stb", 32'(bus.wb_stb_o), 32'd1);
    step();
    rstn = 1'b1;
    raise(0, 1'b0, 8'h01, 8'h00);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 8'h3C;
    sample();
    check("rst gnt", 32'(bus.ch_gnt_o), 32'd0);
    check("rst busy", 32'(bus.busy_o), 32'd0);
    check("rst wb_cyc", 32'(bus.wb_cyc_o), 32'd0);
    check("rst wb_stb", 32'(bus.wb_stb_o), 32'd0);
    check("rst wb_adr", 32'(bus.wb_adr_o), 32'd0);
    check("rst ack", 32'(bus.ch_ack_o), 32'd0);
    check("rst dat passthru", 32'(bus.ch_dat_o), 32'h3C);
    bus.wb_ack_i = 1'b0;
    exp_gnt_q.push_back(0);
    wait_grant("rst ch0 first", 1'b0);

    step();
    drop(0);
    drop(1);
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2c_wb_arbiter.md
# i2c_wb_arbiter

Parametrised Wishbone arbiter that lets NUM_CH independent I2C channel drivers share the single Wishbone slave port of the EFB hard I2C block. Each channel driver acts as a Wishbone master. The arbiter grants the bus round-robin, locks it to one channel for that channel's whole Wishbone cycle, and routes ack and read data back to the owning channel only. A per-strobe ack timeout aborts a hung transfer and releases the bus. It replaces the fixed two-driver wiring inside the I2C top level.

## Interface

Parameters:
- NUM_CH, default 2: number of channel masters; legal range 2–8.
- TIMEOUT, default 255: cycles a strobe may wait for ack before abort; legal range 2–65535.

Ports:
- sys_clk, input, 1: master clock; the only clock.
- rstn, input, 1: reset, synchronous, active-low.
- ch_cyc_i, input, NUM_CH: per-channel Wishbone cycle request.
- ch_stb_i, input, NUM_CH: per-channel strobe.
- ch_we_i, input, NUM_CH: per-channel write enable.
- ch_adr_i, input, 8*NUM_CH: channel k uses bits [8k+7:8k].
- ch_dat_i, input, 8*NUM_CH: write data; channel k uses bits [8k+7:8k].
- ch_dat_o, output, 8: EFB read data, broadcast to all channels.
- ch_ack_o, output, NUM_CH: ack, routed to the owner only.
- ch_gnt_o, output, NUM_CH: one-hot grant.
- ch_err_o, output, NUM_CH: one-cycle timeout pulse to the owner.
- wb_cyc_o, wb_stb_o, wb_we_o, output, 1 each: to the EFB.
- wb_adr_o, wb_dat_o, output, 8 each: to the EFB.
- wb_dat_i, input, 8: read data from the EFB.
- wb_ack_i, input, 1: ack from the EFB.
- busy_o, output, 1: high whenever any channel owns the bus.

## Operation

State machine:
- IDLE → OWN: any ch_cyc_i bit is high. The winner is the first requesting channel scanning upward from last_grant+1, wrapping modulo NUM_CH. The grant index and ch_gnt_o are registered, and last_grant is updated at the same edge.
- OWN → IDLE: the owner's ch_cyc_i is low.
- OWN → ABORT: the timeout fires. ch_err_o[owner] pulses for that cycle.
- ABORT → IDLE: the owner's ch_cyc_i is low.
- IDLE always lasts at least one cycle between owners. This gives the EFB one dead cycle with cyc low.

EFB outputs:
- In OWN, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o and wb_dat_o are combinational copies of the owner's inputs.
- In IDLE and ABORT, all EFB outputs are 0.

Return path:
- ch_ack_o[owner] = wb_ack_i & (state==OWN). All other ack bits are 0.
- ch_dat_o = wb_dat_i, unregistered.

Timeout counter:
- 16 bits.
- Clears to 0 when stb is low or wb_ack_i is high.
- Otherwise increments each cycle while wb_stb_o is high.
- The timeout fires on the cycle the counter equals TIMEOUT-1 with wb_ack_i low.

busy_o = (state != IDLE).

Boundary conditions:
- Ack and timeout in the same cycle: ack wins, no error, counter clears.
- Non-owner channels raising or dropping cyc while another channel owns the bus: ignored until IDLE.
- Owner drops cyc during its ABORT pulse cycle: ch_err_o still pulses, then the next state is IDLE.
- Owner holds cyc with stb low: bus stays locked and the counter stays cleared (intentional; the drivers chain register accesses this way).
- rstn low at any edge:
  - state = IDLE, last_grant = NUM_CH-1 (so channel 0 wins first), counter = 0.
  - All registered outputs = 0; EFB outputs are 0 from that edge onward.

Reset values: ch_gnt_o, ch_err_o, busy_o, wb_* outputs and ch_ack_o are all 0. ch_dat_o tracks wb_dat_i.

## Timing

- Grant latency: ch_cyc_i[k] high before edge n, state IDLE → ch_gnt_o[k] and wb_cyc_o high after edge n.
- Request to EFB stb: 1 cycle, provided the channel asserts stb together with cyc.
- Ack path: zero-cycle combinational, EFB → channel.
- Release: owner cyc low before edge m → IDLE after m → next grant visible after m+1.
- Back-to-back ownership by two channels costs 1 dead cycle.
- Timeout: with stb asserted from cycle s and no ack, ch_err_o pulses in cycle s+TIMEOUT-1 and wb_stb_o is 0 from cycle s+TIMEOUT.

## Test plan

- **Single requester:** NUM_CH=2; ch1 asserts cyc+stb, we=1, adr=0x4A, dat=0x5C; EFB acks on the 3rd cycle.
  Expect ch_gnt_o=2'b10 one cycle later, wb_adr_o=0x4A, wb_dat_o=0x5C, a ch_ack_o[1] pulse, and ch_ack_o[0]=0 throughout.
- **Round-robin:** NUM_CH=4; channels 0–3 all hold cyc continuously and each drops cyc after one acked access.
  Expect grant order 0,1,2,3,0 with exactly one idle cycle between owners.
- **Lock:** ch0 owns the bus and does 3 register reads while ch1 requests continuously.
  Expect ch1 not granted until ch0 drops cyc; read data 0x11, 0x22, 0x33 seen on ch_dat_o at each ch0 ack.
- **Timeout:** TIMEOUT=8; ch2 strobes and the EFB never acks.
  Expect a ch_err_o[2] pulse exactly 7 cycles after stb rises, wb_stb_o=0 thereafter, and busy_o high until ch2 drops cyc.
- **Ack/timeout collision:** TIMEOUT=8; the EFB acks in the same cycle the counter reaches 7.
  Expect ch_ack_o pulse and no ch_err_o.
- **Reset mid-transfer:** rstn low for 1 cycle while ch1 owns the bus with stb high.
  Expect all outputs 0 after that edge; afterwards, with ch0 and ch1 both requesting, ch0 is granted first.
